// File: rtl/clock_mode_controller_pkg.sv
// -----------------------------------------------------------------------------
// clock_mode_controller_pkg
//   Shared definitions for the clock mode controller slice:
//   - mode encodings presented on the mode output and used as FSM states
//   - field widths of the hour/minute/second counters
//   - default moduli and SET-mode timeout
//   - time triple struct and a range-check helper for incoming sync loads
// -----------------------------------------------------------------------------
package clock_mode_controller_pkg;

  // Field widths (binary hour/min/sec)
  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;
  localparam int MODE_W = 2;

  // Default moduli and SET-mode inactivity timeout (in ticks)
  localparam int SEC_MOD_DEF     = 60;
  localparam int MIN_MOD_DEF     = 60;
  localparam int HOUR_MOD_DEF    = 24;
  localparam int SET_TIMEOUT_DEF = 30;

  // Mode / FSM state encodings, visible externally on mode_o
  localparam logic [MODE_W-1:0] MODE_RUN      = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SET_HOUR = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SET_MIN  = 2'd2;

  // One complete time value as carried by the sync interface
  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
  } clk_time_t;

  // True when a field value is a legal counter value for the given modulus
  function automatic logic field_in_range(input logic [7:0] value,
                                          input int unsigned modulus);
    return ({24'd0, value} < modulus);
  endfunction

endpackage

// File: rtl/clock_mode_controller_if.sv
// -----------------------------------------------------------------------------
// clock_mode_controller_if
//   Valid/ready time-load channel between the external synchroniser (master)
//   and the clock mode controller (slave).
//   sync_valid  master->slave  load request, held until accepted
//   sync_hour   master->slave  requested hours
//   sync_min    master->slave  requested minutes
//   sync_sec    master->slave  requested seconds
//   sync_ready  slave->master  high while the controller can accept a load
//   sync_err    slave->master  1-cycle pulse: accepted load had a bad field
// -----------------------------------------------------------------------------
interface clock_mode_controller_if;
  import clock_mode_controller_pkg::*;

  logic              sync_valid;
  logic [HOUR_W-1:0] sync_hour;
  logic [MIN_W-1:0]  sync_min;
  logic [SEC_W-1:0]  sync_sec;
  logic              sync_ready;
  logic              sync_err;

  modport master (
    output sync_valid,
    output sync_hour,
    output sync_min,
    output sync_sec,
    input  sync_ready,
    input  sync_err
  );

  modport slave (
    input  sync_valid,
    input  sync_hour,
    input  sync_min,
    input  sync_sec,
    output sync_ready,
    output sync_err
  );

endinterface

// File: rtl/clock_mode_controller_mod_n_counter.sv
// -----------------------------------------------------------------------------
// mod_n_counter
//   Modulo-N binary counter used for the seconds, minutes and hours fields.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset (clears to 0)
//     inc_i         advance by one, wrapping N-1 -> 0
//     load_i        load load_val_i (takes priority over inc_i)
//     load_val_i    value to load
//     q_o           current count (registered)
//     wrap_o        count is at N-1, i.e. the next increment wraps; this is a
//                   pure decode of the register so the parent can build the
//                   carry chain without a combinational path through inc_i
// -----------------------------------------------------------------------------
module mod_n_counter #(
  parameter int N = 60,
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] q_o,
  output logic         wrap_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;
  logic         at_max_s;

  assign at_max_s = (q_q == W'(N - 1));
  assign wrap_o   = at_max_s;
  assign q_o      = q_q;

  // Next count: load beats increment; increment wraps at N-1
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (inc_i) begin
      if (at_max_s) begin
        q_d = {W{1'b0}};
      end else begin
        q_d = q_q + W'(1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= {W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// -----------------------------------------------------------------------------
// clock_mode_controller
//   Mode and sequencing controller for the sec/min/hour counter chain.
//   RUN advances time on 1 Hz ticks; SET_HOUR / SET_MIN let the user adjust
//   the time with two buttons; a valid/ready channel accepts whole-time loads
//   from the external synchroniser while in RUN.
//   Ports:
//     clk          system clock
//     reset        asynchronous, active-high reset
//     tick_i       1-cycle 1 Hz pulse
//     btn_mode_i   1-cycle pulse: advance mode RUN->SET_HOUR->SET_MIN->RUN
//     btn_inc_i    1-cycle pulse: increment the field being set
//     sync_if      time-load channel (slave side)
//     hour_o       current hours
//     min_o        current minutes
//     sec_o        current seconds
//     mode_o       0=RUN 1=SET_HOUR 2=SET_MIN
//     blink_o      blink phase of the field being set, 0 in RUN
//     day_pulse_o  1-cycle pulse on the 23:59:59 -> 00:00:00 rollover
//   All outputs are registered: an input event in cycle n shows in cycle n+1.
// -----------------------------------------------------------------------------
module clock_mode_controller
  import clock_mode_controller_pkg::*;
#(
  parameter int SEC_MOD     = SEC_MOD_DEF,
  parameter int MIN_MOD     = MIN_MOD_DEF,
  parameter int HOUR_MOD    = HOUR_MOD_DEF,
  parameter int SET_TIMEOUT = SET_TIMEOUT_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick_i,
  input  logic                   btn_mode_i,
  input  logic                   btn_inc_i,
  clock_mode_controller_if.slave sync_if,
  output logic [HOUR_W-1:0]      hour_o,
  output logic [MIN_W-1:0]       min_o,
  output logic [SEC_W-1:0]       sec_o,
  output logic [MODE_W-1:0]      mode_o,
  output logic                   blink_o,
  output logic                   day_pulse_o
);

  localparam int TO_W = $clog2(SET_TIMEOUT + 1);

  // FSM and status registers
  logic [MODE_W-1:0] mode_q,       mode_d;
  logic [TO_W-1:0]   timeout_q,    timeout_d;
  logic              blink_q,      blink_d;
  logic              sync_err_q,   sync_err_d;
  logic              day_pulse_q,  day_pulse_d;
  logic              sync_ready_q, sync_ready_d;

  // Counter controls and observations
  logic              sec_inc_s,  min_inc_s,  hour_inc_s;
  logic              sec_load_s, min_load_s, hour_load_s;
  logic [SEC_W-1:0]  sec_load_val_s;
  logic              sec_wrap_s, min_wrap_s, hour_wrap_s;
  logic [SEC_W-1:0]  sec_val_s;
  logic [MIN_W-1:0]  min_val_s;
  logic [HOUR_W-1:0] hour_val_s;

  // Sync channel decode
  clk_time_t         sync_time_s;
  logic              sync_xfer_s;
  logic              sync_ok_s;

  // Timeout arithmetic
  logic [TO_W-1:0]   timeout_inc_s;
  logic              timeout_hit_s;

  assign sync_time_s = {sync_if.sync_hour, sync_if.sync_min, sync_if.sync_sec};

  // A transfer only happens while ready, and ready is only high in RUN
  assign sync_xfer_s = sync_if.sync_valid & sync_ready_q;

  assign sync_ok_s = field_in_range({3'b000, sync_time_s.hour}, HOUR_MOD) &
                     field_in_range({2'b00,  sync_time_s.min},  MIN_MOD)  &
                     field_in_range({2'b00,  sync_time_s.sec},  SEC_MOD);

  // The tick that would reach SET_TIMEOUT is the one that expires the mode
  assign timeout_inc_s = timeout_q + TO_W'(1);
  assign timeout_hit_s = (timeout_inc_s == TO_W'(SET_TIMEOUT));

  // Mode FSM, time-advance decisions, blink, timeout and sync checks
  always_comb begin
    mode_d         = mode_q;
    timeout_d      = timeout_q;
    blink_d        = blink_q;
    sync_err_d     = 1'b0;
    day_pulse_d    = 1'b0;
    sec_inc_s      = 1'b0;
    min_inc_s      = 1'b0;
    hour_inc_s     = 1'b0;
    sec_load_s     = 1'b0;
    min_load_s     = 1'b0;
    hour_load_s    = 1'b0;
    sec_load_val_s = sync_time_s.sec;

    case (mode_q)
      MODE_RUN: begin
        blink_d   = 1'b0;
        timeout_d = {TO_W{1'b0}};
        // A sync transfer swallows a coincident tick
        if (sync_xfer_s) begin
          if (sync_ok_s) begin
            sec_load_s  = 1'b1;
            min_load_s  = 1'b1;
            hour_load_s = 1'b1;
          end else begin
            sync_err_d  = 1'b1;
          end
        end else if (tick_i) begin
          sec_inc_s   = 1'b1;
          min_inc_s   = sec_wrap_s;
          hour_inc_s  = sec_wrap_s & min_wrap_s;
          day_pulse_d = sec_wrap_s & min_wrap_s & hour_wrap_s;
        end else begin
          sec_inc_s   = 1'b0;
        end
        if (btn_mode_i) begin
          mode_d  = MODE_SET_HOUR;
          blink_d = 1'b1;
        end else begin
          mode_d  = MODE_RUN;
        end
      end

      MODE_SET_HOUR, MODE_SET_MIN: begin
        // Buttons beat tick and timeout; btn_mode beats btn_inc
        if (btn_mode_i) begin
          timeout_d = {TO_W{1'b0}};
          if (mode_q == MODE_SET_HOUR) begin
            mode_d  = MODE_SET_MIN;
            blink_d = 1'b1;
          end else begin
            mode_d         = MODE_RUN;
            blink_d        = 1'b0;
            sec_load_s     = 1'b1;
            sec_load_val_s = {SEC_W{1'b0}};
          end
        end else if (btn_inc_i) begin
          timeout_d = {TO_W{1'b0}};
          blink_d   = 1'b1;
          // No carry between fields while setting
          if (mode_q == MODE_SET_HOUR) begin
            hour_inc_s = 1'b1;
          end else begin
            min_inc_s  = 1'b1;
          end
        end else if (tick_i) begin
          if (timeout_hit_s) begin
            mode_d    = MODE_RUN;
            blink_d   = 1'b0;
            timeout_d = {TO_W{1'b0}};
          end else begin
            blink_d   = ~blink_q;
            timeout_d = timeout_inc_s;
          end
        end else begin
          timeout_d = timeout_q;
        end
      end

      default: begin
        mode_d    = MODE_RUN;
        blink_d   = 1'b0;
        timeout_d = {TO_W{1'b0}};
      end
    endcase
  end

  // Ready is registered from the next mode so it tracks mode_o exactly
  assign sync_ready_d = (mode_d == MODE_RUN);

  // FSM / status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q       <= MODE_RUN;
      timeout_q    <= {TO_W{1'b0}};
      blink_q      <= 1'b0;
      sync_err_q   <= 1'b0;
      day_pulse_q  <= 1'b0;
      sync_ready_q <= 1'b1;
    end else begin
      mode_q       <= mode_d;
      timeout_q    <= timeout_d;
      blink_q      <= blink_d;
      sync_err_q   <= sync_err_d;
      day_pulse_q  <= day_pulse_d;
      sync_ready_q <= sync_ready_d;
    end
  end

  mod_n_counter #(.N(SEC_MOD), .W(SEC_W)) u_sec (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (sec_inc_s),
    .load_i     (sec_load_s),
    .load_val_i (sec_load_val_s),
    .q_o        (sec_val_s),
    .wrap_o     (sec_wrap_s)
  );

  mod_n_counter #(.N(MIN_MOD), .W(MIN_W)) u_min (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (min_inc_s),
    .load_i     (min_load_s),
    .load_val_i (sync_time_s.min),
    .q_o        (min_val_s),
    .wrap_o     (min_wrap_s)
  );

  mod_n_counter #(.N(HOUR_MOD), .W(HOUR_W)) u_hour (
    .clk        (clk),
    .reset      (reset),
    .inc_i      (hour_inc_s),
    .load_i     (hour_load_s),
    .load_val_i (sync_time_s.hour),
    .q_o        (hour_val_s),
    .wrap_o     (hour_wrap_s)
  );

  assign hour_o             = hour_val_s;
  assign min_o              = min_val_s;
  assign sec_o              = sec_val_s;
  assign mode_o             = mode_q;
  assign blink_o            = blink_q;
  assign day_pulse_o        = day_pulse_q;
  assign sync_if.sync_ready = sync_ready_q;
  assign sync_if.sync_err   = sync_err_q;

endmodule
